// File: rtl/instr_loader.sv
// instr_loader: fills instruction memory from a byte stream before the CPU runs.
// Bytes are packed big-endian into 32-bit words. Each word is written one cycle
// after its last byte is accepted, at word-aligned byte addresses counting up from BASE_ADDR.
// Flow control: valid/ready. in_ready is high only in LOAD and drops for the one-cycle WRITE.
// Ports: clk/reset (async, active-high); start pulse; in_valid/in_data/in_last/in_ready
// byte stream; mem_we/mem_addr/mem_wdata word write port; cpu_hold, done, err, word_count status.
// Optional macro LOADER_CKSUM_EN adds output cksum, the mod-2^32 sum of the words written.
module instr_loader #(
    parameter int          ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          MAX_WORDS = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_count
`ifdef LOADER_CKSUM_EN
    ,
    output logic [31:0]       cksum
`endif
);

    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
    localparam logic [15:0]       MAX_WC = 16'(MAX_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_q, last_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       wc_q, wc_d;
    logic [31:0]       cksum_q, cksum_d;
    logic              accept;

    // in_ready_q is high exactly while in LOAD, so it doubles as the accept qualifier.
    assign accept = in_ready_q & in_valid;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        addr_d      = addr_q;
        last_d      = last_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        err_d       = err_q;
        wc_d        = wc_q;
        cksum_d     = cksum_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    wc_d       = '0;
                    addr_d     = BASE;
                    idx_d      = '0;
                    buf_d      = '0;
                    last_d     = 1'b0;
                    cksum_d    = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    case (idx_q)
                        2'd0:    buf_d[31:24] = in_data;
                        2'd1:    buf_d[23:16] = in_data;
                        2'd2:    buf_d[15:8]  = in_data;
                        default: buf_d[7:0]   = in_data;
                    endcase
                    idx_d = idx_q + 2'd1;
                    if (in_last) begin
                        last_d = 1'b1;
                        // A short final word is still written, zero-padded, but the stream was malformed.
                        if (idx_q != 2'd3) begin
                            err_d = 1'b1;
                        end
                    end
                    if (idx_q == 2'd3 || in_last) begin
                        state_d = S_WRITE;
                        // A word arriving once capacity is used up is dropped and ends the session.
                        if (wc_q == MAX_WC) begin
                            err_d = 1'b1;
                        end else begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = addr_q;
                            mem_wdata_d = buf_d;
                        end
                    end
                end
            end
            S_WRITE: begin
                if (mem_we_q) begin
                    addr_d  = addr_q + ADDR_W'(4);
                    wc_d    = wc_q + 16'd1;
                    cksum_d = cksum_q + mem_wdata_q;
                end
                buf_d   = '0;
                idx_d   = '0;
                // mem_we_q low here means the word was refused for capacity.
                state_d = (last_q || !mem_we_q) ? S_DONE : S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_DONE) begin
            cpu_hold_d = 1'b0;
            done_d     = 1'b1;
        end
        in_ready_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            buf_q       <= '0;
            addr_q      <= BASE;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            wc_q        <= '0;
            cksum_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            buf_q       <= buf_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wc_q        <= wc_d;
            cksum_q     <= cksum_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = wc_q;

`ifdef LOADER_CKSUM_EN
    assign cksum = cksum_q;
`else
    // Sum tracking is unused in this build; keep it from reaching any port.
    logic unused_cksum;
    assign unused_cksum = ^cksum_q;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: drives byte streams with random gaps and checks the results
// against a word-level reference model computed from the byte list.
module tb_instr_loader;

    localparam int ADDR_W = 16;
    localparam int BASE   = 0;
    localparam int MAXW   = 3;

    logic              clk = 1'b0;
    logic              reset, start, in_valid, in_last;
    logic [7:0]        in_data;
    logic              in_ready, mem_we, cpu_hold, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [15:0]       word_count;
`ifdef LOADER_CKSUM_EN
    logic [31:0]       cksum;
`endif

    instr_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err), .word_count(word_count)
`ifdef LOADER_CKSUM_EN
        , .cksum(cksum)
`endif
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int miscmp  = 0;
    int cyc     = 0;
    int acc_cnt = 0;
    int last_cmp_cyc = -10;
    logic [31:0] wr_data_q[$];
    logic [31:0] wr_addr_q[$];
    logic [7:0]  stim[$];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: record writes, verify write latency and in_ready low during a write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            check("we_latency", cyc, last_cmp_cyc + 1);
            check("rdy_in_write", {31'b0, in_ready}, 32'd0);
            wr_addr_q.push_back(32'(mem_addr));
            wr_data_q.push_back(mem_wdata);
        end
        if (reset === 1'b0 && in_valid === 1'b1 && in_ready === 1'b1) begin
            acc_cnt++;
            if (acc_cnt % 4 == 0 || in_last) last_cmp_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".in_ready"}, {31'b0, in_ready}, 32'd0);
        check({tag, ".mem_we"}, {31'b0, mem_we}, 32'd0);
        check({tag, ".mem_addr"}, 32'(mem_addr), 32'(BASE));
        check({tag, ".mem_wdata"}, mem_wdata, 32'd0);
        check({tag, ".cpu_hold"}, {31'b0, cpu_hold}, 32'd0);
        check({tag, ".done"}, {31'b0, done}, 32'd0);
        check({tag, ".err"}, {31'b0, err}, 32'd0);
        check({tag, ".word_count"}, 32'(word_count), 32'd0);
`ifdef LOADER_CKSUM_EN
        check({tag, ".cksum"}, cksum, 32'd0);
`endif
    endtask

    task automatic do_start();
        wr_addr_q.delete();
        wr_data_q.delete();
        acc_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("start.cpu_hold", {31'b0, cpu_hold}, 32'd1);
        check("start.done", {31'b0, done}, 32'd0);
        check("start.err", {31'b0, err}, 32'd0);
        check("start.word_count", 32'(word_count), 32'd0);
        check("start.in_ready", {31'b0, in_ready}, 32'd1);
        tick();
    endtask

    task automatic send_bytes(input int n, input bit with_last, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = stim[i];
            in_last  = with_last && (i == n - 1);
            for (int t = 0; t <= 50; t++) begin
                @(negedge clk);
                if (in_ready === 1'b1) break;
                if (t == 50) begin
                    check("accept_timeout", {31'b0, in_ready}, 32'd1);
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                    return;
                end
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        check("done_seen", {31'b0, done}, 32'd1);
        tick();
    endtask

    // Reference model: words are 4-byte big-endian chunks of the stream, a short tail is
    // zero-padded, only the first MAXW words are written.
    task automatic check_session(input string tag, input int n, input bit with_last);
        int          nwords, nwr;
        logic        exp_err;
        logic [31:0] word, sum;
        nwords  = with_last ? (n + 3) / 4 : n / 4;
        nwr     = (nwords < MAXW) ? nwords : MAXW;
        exp_err = (with_last && (n % 4 != 0)) || (nwords > MAXW);
        sum     = 32'd0;
        @(negedge clk);
        check({tag, ".nwrites"}, 32'(wr_data_q.size()), 32'(nwr));
        for (int w = 0; w < nwr; w++) begin
            word = 32'd0;
            for (int b = 0; b < 4; b++)
                word = (word << 8) | ((4 * w + b < n) ? 32'(stim[4 * w + b]) : 32'd0);
            sum += word;
            if (w < wr_data_q.size()) begin
                check({tag, ".addr"}, wr_addr_q[w], 32'(BASE + 4 * w));
                check({tag, ".data"}, wr_data_q[w], word);
            end
        end
        check({tag, ".done"}, {31'b0, done}, 32'd1);
        check({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
        check({tag, ".word_count"}, 32'(word_count), 32'(nwr));
        check({tag, ".cpu_hold"}, {31'b0, cpu_hold}, 32'd0);
        check({tag, ".in_ready"}, {31'b0, in_ready}, 32'd0);
`ifdef LOADER_CKSUM_EN
        check({tag, ".cksum"}, cksum, sum);
`endif
        tick();
    endtask

    task automatic fill_random(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
    endtask

    initial begin
        int n, nwr_before;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        tick();

        // Bytes offered while idle must not be consumed.
        in_valid = 1'b1; in_data = 8'h5A;
        repeat (3) tick();
        @(negedge clk);
        check("idle.in_ready", {31'b0, in_ready}, 32'd0);
        check("idle.nwrites", 32'(wr_data_q.size()), 32'd0);
        in_valid = 1'b0;
        tick();

        // Basic two-word program.
        stim = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
        do_start();
        send_bytes(8, 1'b1, 0);
        wait_done();
        check_session("basic", 8, 1'b1);

        // Same stream with gaps, restarted from DONE.
        do_start();
        send_bytes(8, 1'b1, 40);
        wait_done();
        check_session("gaps", 8, 1'b1);

        // Short final word.
        stim = '{8'hAA, 8'hBB};
        do_start();
        send_bytes(2, 1'b1, 0);
        wait_done();
        check_session("partial", 2, 1'b1);

        // Capacity overflow without in_last.
        fill_random(4 * (MAXW + 1));
        do_start();
        send_bytes(4 * (MAXW + 1), 1'b0, 20);
        wait_done();
        check_session("capacity", 4 * (MAXW + 1), 1'b0);

        // Reset mid-session.
        fill_random(8);
        do_start();
        send_bytes(5, 1'b0, 0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        nwr_before = wr_data_q.size();
        check("midrst.prior_writes", 32'(nwr_before), 32'd1);
        in_valid = 1'b1; in_data = 8'h11;
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst.no_more_writes", 32'(wr_data_q.size()), 32'(nwr_before));
        check("midrst.in_ready", {31'b0, in_ready}, 32'd0);
        tick();

        // Checksum wraparound session, then a fresh session.
        stim = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_start();
        send_bytes(8, 1'b1, 0);
        wait_done();
        check_session("cksum1", 8, 1'b1);
        stim = '{8'h00, 8'h00, 8'h00, 8'h03};
        do_start();
        send_bytes(4, 1'b1, 10);
        wait_done();
        check_session("cksum2", 4, 1'b1);

        // Randomised sessions, lengths up to one word beyond capacity.
        for (int s = 0; s < 20; s++) begin
            n = $urandom_range(1, 4 * (MAXW + 1));
            fill_random(n);
            do_start();
            send_bytes(n, 1'b1, $urandom_range(0, 50));
            wait_done();
            check_session("random", n, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
